// File: rtl/scratchmem_arbiter.sv
// Round-robin arbiter sharing one scratch memory port among NREQ Wishbone-classic requesters.
// Memory bus is registered one cycle after a request; requesters stall by holding stb until ack/err.
module scratchmem_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 31
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_cyc_i,
  input  logic [NREQ-1:0]      req_stb_i,
  input  logic [NREQ-1:0]      req_we_i,
  input  logic [4*NREQ-1:0]    req_sel_i,
  input  logic [32*NREQ-1:0]   req_adr_i,
  input  logic [32*NREQ-1:0]   req_dat_i,
  output logic [NREQ-1:0]      req_ack_o,
  output logic [NREQ-1:0]      req_err_o,
  output logic [31:0]          req_dat_o,
  output logic [NREQ-1:0]      grant_o,
  output logic                 mem_cs_o,
  output logic                 mem_cyc_o,
  output logic                 mem_stb_o,
  output logic                 mem_we_o,
  output logic [3:0]           mem_sel_o,
  output logic [31:0]          mem_adr_o,
  output logic [31:0]          mem_dat_o,
  input  logic                 mem_ack_i,
  input  logic [31:0]          mem_dat_i
);

  localparam int IW = (NREQ > 2) ? 2 : 1;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_nxt;
  logic [IW-1:0]     last_grant, last_nxt;
  logic [IW-1:0]     gidx, gidx_nxt;
  logic [IW-1:0]     win;
  logic [NREQ-1:0]   reqs;
  logic [NREQ-1:0]   grant_nxt, ack_nxt, err_nxt;
  logic              strb, strb_nxt;
  logic              we_nxt;
  logic [3:0]        sel_nxt;
  logic [31:0]       adr_nxt, wdat_nxt, rdat_nxt;
  logic [7:0]        tmo_cnt, tmo_nxt;

  // First requester found searching upward from the one after the last grant.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] last);
    logic [IW-1:0] pick;
    logic          found;
    int            idx;
    pick  = '0;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = (int'(last) + i) % NREQ;
      if (!found && r[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
    return pick;
  endfunction

  assign reqs = req_cyc_i & req_stb_i;
  assign win  = rr_pick(reqs, last_grant);

  always_comb begin
    state_nxt = state;
    last_nxt  = last_grant;
    gidx_nxt  = gidx;
    grant_nxt = grant_o;
    strb_nxt  = strb;
    we_nxt    = mem_we_o;
    sel_nxt   = mem_sel_o;
    adr_nxt   = mem_adr_o;
    wdat_nxt  = mem_dat_o;
    rdat_nxt  = req_dat_o;
    tmo_nxt   = tmo_cnt;
    ack_nxt   = '0;
    err_nxt   = '0;
    case (state)
      IDLE: begin
        if (|reqs) begin
          state_nxt      = BUSY;
          last_nxt       = win;
          gidx_nxt       = win;
          grant_nxt      = '0;
          grant_nxt[win] = 1'b1;
          strb_nxt       = 1'b1;
          we_nxt         = req_we_i[win];
          sel_nxt        = req_sel_i[4*win +: 4];
          adr_nxt        = req_adr_i[32*win +: 32];
          wdat_nxt       = req_dat_i[32*win +: 32];
          tmo_nxt        = '0;
        end
      end
      BUSY: begin
        if (tmo_cnt != 8'hFF) tmo_nxt = tmo_cnt + 8'd1;
        // Ack beats timeout, timeout beats abort.
        if (mem_ack_i) begin
          ack_nxt[gidx] = 1'b1;
          rdat_nxt      = mem_dat_i;
          strb_nxt      = 1'b0;
          state_nxt     = DONE;
        end else if (tmo_cnt == TMO_LAST) begin
          err_nxt[gidx] = 1'b1;
          rdat_nxt      = '0;
          strb_nxt      = 1'b0;
          state_nxt     = DONE;
        end else if (!req_cyc_i[gidx]) begin
          strb_nxt  = 1'b0;
          grant_nxt = '0;
          state_nxt = IDLE;
        end
      end
      DONE: begin
        strb_nxt  = 1'b0;
        grant_nxt = '0;
        state_nxt = IDLE;
      end
      default: begin
        strb_nxt  = 1'b0;
        grant_nxt = '0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      last_grant <= IW'(NREQ - 1);
      gidx       <= '0;
      grant_o    <= '0;
      strb       <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_sel_o  <= '0;
      mem_adr_o  <= '0;
      mem_dat_o  <= '0;
      req_dat_o  <= '0;
      tmo_cnt    <= '0;
      req_ack_o  <= '0;
      req_err_o  <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_nxt;
      gidx       <= gidx_nxt;
      grant_o    <= grant_nxt;
      strb       <= strb_nxt;
      mem_we_o   <= we_nxt;
      mem_sel_o  <= sel_nxt;
      mem_adr_o  <= adr_nxt;
      mem_dat_o  <= wdat_nxt;
      req_dat_o  <= rdat_nxt;
      tmo_cnt    <= tmo_nxt;
      req_ack_o  <= ack_nxt;
      req_err_o  <= err_nxt;
    end
  end

  assign mem_cs_o  = strb;
  assign mem_cyc_o = strb;
  assign mem_stb_o = strb;

endmodule

// File: tb/tb_scratchmem_arbiter.sv
// Directed bench for scratchmem_arbiter: transaction table plus abort, contention and reset sequences.
module tb_scratchmem_arbiter;
  localparam int NREQ    = 2;
  localparam int TIMEOUT = 4;

  logic                clk_i = 1'b0;
  logic                rst_i = 1'b0;
  logic [NREQ-1:0]     req_cyc_i, req_stb_i, req_we_i;
  logic [4*NREQ-1:0]   req_sel_i;
  logic [32*NREQ-1:0]  req_adr_i, req_dat_i;
  logic [NREQ-1:0]     req_ack_o, req_err_o, grant_o;
  logic [31:0]         req_dat_o;
  logic                mem_cs_o, mem_cyc_o, mem_stb_o, mem_we_o;
  logic [3:0]          mem_sel_o;
  logic [31:0]         mem_adr_o, mem_dat_o;
  logic                mem_ack_i;
  logic [31:0]         mem_dat_i;

  int ack_delay = 255;
  int cs_cnt;
  int n_checks = 0;
  int n_errors = 0;

  scratchmem_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_cyc_i(req_cyc_i), .req_stb_i(req_stb_i), .req_we_i(req_we_i),
    .req_sel_i(req_sel_i), .req_adr_i(req_adr_i), .req_dat_i(req_dat_i),
    .req_ack_o(req_ack_o), .req_err_o(req_err_o), .req_dat_o(req_dat_o),
    .grant_o(grant_o),
    .mem_cs_o(mem_cs_o), .mem_cyc_o(mem_cyc_o), .mem_stb_o(mem_stb_o),
    .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o), .mem_adr_o(mem_adr_o),
    .mem_dat_o(mem_dat_o), .mem_ack_i(mem_ack_i), .mem_dat_i(mem_dat_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory model: acks combinationally ack_delay cycles after cs rises.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         cs_cnt <= 0;
    else if (mem_cs_o) cs_cnt <= cs_cnt + 1;
    else               cs_cnt <= 0;
  end
  assign mem_ack_i = mem_cs_o && (cs_cnt == ack_delay);

  typedef struct {
    logic [1:0]  req;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    int          delay;
    logic [31:0] rd;
    logic [1:0]  exp_grant;
    logic        exp_err;
    logic [31:0] exp_dat;
    int          exp_lat;
  } vec_t;

  vec_t vecs[6];
  vec_t v;
  int   lat, n, bad;
  logic stable;
  logic [1:0] g_seq[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive_req(input int k, input logic on, input logic we, input logic [3:0] sel,
                           input logic [31:0] adr, input logic [31:0] dat);
    req_cyc_i[k]         = on;
    req_stb_i[k]         = on;
    req_we_i[k]          = we;
    req_sel_i[4*k +: 4]  = sel;
    req_adr_i[32*k +: 32] = adr;
    req_dat_i[32*k +: 32] = dat;
  endtask

  task automatic check_zero(input string name);
    chk({name, "_ctrl"}, {req_ack_o, req_err_o, grant_o, mem_cs_o, mem_cyc_o, mem_stb_o, mem_we_o, mem_sel_o}, '0);
    chk({name, "_rdat"}, req_dat_o, '0);
    chk({name, "_adr"}, mem_adr_o, '0);
    chk({name, "_wdat"}, mem_dat_o, '0);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  initial begin
    req_cyc_i = '0; req_stb_i = '0; req_we_i = '0;
    req_sel_i = '0; req_adr_i = '0; req_dat_i = '0;
    mem_dat_i = '0;

    //            req    we    sel   adr          dat           dly  rd            grant  err   exp_dat       lat
    vecs[0] = '{2'b01, 1'b0, 4'hF, 32'h100, 32'h0,        3,   32'hDEADBEEF, 2'b01, 1'b0, 32'hDEADBEEF, 4};
    vecs[1] = '{2'b10, 1'b1, 4'h5, 32'h204, 32'h11223344, 1,   32'hCAFE0001, 2'b10, 1'b0, 32'hCAFE0001, 2};
    vecs[2] = '{2'b01, 1'b0, 4'hF, 32'h208, 32'h0,        255, 32'h55555555, 2'b01, 1'b1, 32'h0,        4};
    vecs[3] = '{2'b01, 1'b0, 4'h3, 32'h300, 32'h0,        0,   32'h12345678, 2'b01, 1'b0, 32'h12345678, 1};
    vecs[4] = '{2'b11, 1'b0, 4'hF, 32'h40C, 32'h0,        2,   32'hA5A5A5A5, 2'b10, 1'b0, 32'hA5A5A5A5, 3};
    vecs[5] = '{2'b11, 1'b1, 4'hC, 32'h410, 32'h9ABCDEF0, 0,   32'h0F0F0F0F, 2'b01, 1'b0, 32'h0F0F0F0F, 1};

    #2 rst_i = 1'b1;
    #1 check_zero("reset");
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    for (int i = 0; i < 6; i++) begin
      v = vecs[i];
      ack_delay = v.delay;
      mem_dat_i = v.rd;
      for (int k = 0; k < NREQ; k++) drive_req(k, v.req[k], v.we, v.sel, v.adr, v.dat);
      tick();
      chk($sformatf("v%0d_cs_rise", i), {mem_cs_o, mem_cyc_o, mem_stb_o}, 3'b111);
      chk($sformatf("v%0d_grant", i), grant_o, v.exp_grant);
      chk($sformatf("v%0d_adr", i), mem_adr_o, v.adr);
      chk($sformatf("v%0d_we_sel_dat", i), {mem_we_o, mem_sel_o, mem_dat_o}, {v.we, v.sel, v.dat});
      lat = 0;
      stable = 1'b1;
      while (lat < 20 && (req_ack_o | req_err_o) == '0) begin
        tick();
        lat++;
        if (mem_cs_o && ({mem_we_o, mem_sel_o, mem_adr_o, mem_dat_o} !== {v.we, v.sel, v.adr, v.dat}))
          stable = 1'b0;
      end
      chk($sformatf("v%0d_latency", i), lat, v.exp_lat);
      chk($sformatf("v%0d_resp", i), {req_err_o, req_ack_o},
          v.exp_err ? {v.exp_grant, 2'b00} : {2'b00, v.exp_grant});
      chk($sformatf("v%0d_rdata", i), req_dat_o, v.exp_dat);
      chk($sformatf("v%0d_cs_low_at_resp", i), mem_cs_o, 1'b0);
      chk($sformatf("v%0d_bus_stable", i), stable, 1'b1);
      for (int k = 0; k < NREQ; k++) drive_req(k, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      tick();
      chk($sformatf("v%0d_one_cycle_resp", i), {req_err_o, req_ack_o, grant_o}, '0);
    end

    // Contention: both requesters hold reads continuously from reset.
    ack_delay = 1;
    mem_dat_i = 32'h0BADCAFE;
    drive_req(0, 1'b1, 1'b0, 4'hF, 32'h600, 32'h0);
    drive_req(1, 1'b1, 1'b0, 4'hF, 32'h700, 32'h0);
    do_reset();
    n = 0;
    bad = 0;
    for (int c = 0; c < 60 && n < 4; c++) begin
      tick();
      if (((req_ack_o | req_err_o) & ~grant_o) != '0) bad++;
      if (req_ack_o != '0) begin
        g_seq[n] = req_ack_o;
        chk($sformatf("cont_cs_gap%0d", n), {mem_cs_o, mem_cyc_o, mem_stb_o}, 3'b000);
        n++;
      end
    end
    chk("cont_count", n, 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("cont_order%0d", i), g_seq[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    chk("cont_misdirected", bad, 0);
    drive_req(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive_req(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) tick();

    // Abort: requester 0 drops cyc one cycle after grant, requester 1 waits.
    do_reset();
    ack_delay = 255;
    mem_dat_i = 32'h600DF00D;
    drive_req(0, 1'b1, 1'b0, 4'hF, 32'h800, 32'h0);
    tick();
    chk("abort_grant0", grant_o, 2'b01);
    drive_req(0, 1'b0, 1'b0, 4'hF, 32'h800, 32'h0);
    drive_req(1, 1'b1, 1'b0, 4'hF, 32'h900, 32'h0);
    tick();
    chk("abort_cs_drop", {mem_cs_o, mem_cyc_o, mem_stb_o}, 3'b000);
    chk("abort_grant_drop", grant_o, 2'b00);
    chk("abort_no_resp", {req_err_o, req_ack_o}, 4'b0000);
    ack_delay = 0;
    tick();
    chk("abort_grant1", {grant_o, mem_cs_o}, 3'b101);
    chk("abort_r1_adr", mem_adr_o, 32'h900);
    tick();
    chk("abort_r1_ack", {req_err_o, req_ack_o}, 4'b0010);
    chk("abort_r1_rdata", req_dat_o, 32'h600DF00D);
    drive_req(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    tick();

    // Reset asserted mid-transfer, then simultaneous requests.
    ack_delay = 255;
    drive_req(0, 1'b1, 1'b0, 4'hF, 32'h500, 32'h77777777);
    tick();
    chk("rstmid_busy", {grant_o, mem_cs_o}, 3'b011);
    drive_req(1, 1'b1, 1'b0, 4'hF, 32'hA00, 32'h0);
    #2 rst_i = 1'b1;
    #1 check_zero("rstmid");
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();
    chk("rstmid_restart_grant", grant_o, 2'b01);
    chk("rstmid_restart_adr", mem_adr_o, 32'h500);
    ack_delay = 0;
    tick();
    chk("rstmid_restart_ack", {req_err_o, req_ack_o}, 4'b0001);
    drive_req(0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    drive_req(1, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
